// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the UART arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy;
  logic grant_valid;
  logic [ID_W-1:0] grant_id;
  logic timeout_flag;
  modport master (
    input req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_flag
  );
  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_flag
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locked sharing of one UART transmitter; UART_ARB_TIMEOUT_EN adds forced release of stalled owners
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT_CYCLES = 5208
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_grant, last_grant_n, gid, gid_n, winner;
  logic [NUM_REQ-1:0] ready, ready_n;
  logic [7:0] data, data_n, sel_data;
  logic start, start_n, gv, gv_n, last_q, last_q_n, tflag, tflag_n;
  logic found, sel_valid, sel_last, accept, done, fire;
  assign accept = state == SEND && sel_valid && !bus.tx_busy;
  assign done = state == WAIT_DONE && !bus.tx_busy && last_q;
`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] stall_cnt;
  logic stall;
  assign stall = state == SEND && !sel_valid;
  assign fire = stall && stall_cnt == 32'(TIMEOUT_CYCLES - 1);
  // stall counter restarts on every entry to SEND and on every accepted byte
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else stall_cnt <= (state != SEND || accept || fire) ? '0 : stall ? stall_cnt + 32'd1 : stall_cnt;
  end
`else
  logic unused_timeout;
  assign fire = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif
  // owner's byte mux and circular winner search starting after last_grant
  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    winner = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == gid) begin
        sel_valid = bus.req_valid[j];
        sel_last = bus.req_last[j];
        sel_data = bus.req_data[8*j +: 8];
      end
    end
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (bus.req_valid[j] && (int'(last_grant) + i) % NUM_REQ == j) begin
          winner = ID_W'(j);
          found = 1'b1;
        end
      end
    end
  end
  // next-state logic; the owner is never re-arbitrated while a packet is open
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = found ? SEND : IDLE;
      SEND: state_n = fire ? IDLE : accept ? WAIT_ACK : SEND;
      WAIT_ACK: state_n = bus.tx_busy ? WAIT_DONE : WAIT_ACK;
      default: state_n = bus.tx_busy ? WAIT_DONE : last_q ? IDLE : SEND;
    endcase
  end
  // next values of the registered outputs
  always_comb begin
    start_n = accept;
    ready_n = accept ? NUM_REQ'(1) << gid : '0;
    data_n = accept ? sel_data : data;
    last_q_n = accept ? sel_last : last_q;
    gid_n = (state == IDLE && found) ? winner : gid;
    gv_n = (state == IDLE) ? found : !(done || fire);
    last_grant_n = (done || fire) ? gid : last_grant;
    tflag_n = fire;
  end
  // state and output registers; reset points last_grant so requester 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      gid <= '0;
      ready <= '0;
      data <= '0;
      start <= 1'b0;
      gv <= 1'b0;
      last_q <= 1'b0;
      tflag <= 1'b0;
    end else begin
      state <= state_n;
      last_grant <= last_grant_n;
      gid <= gid_n;
      ready <= ready_n;
      data <= data_n;
      start <= start_n;
      gv <= gv_n;
      last_q <= last_q_n;
      tflag <= tflag_n;
    end
  end
  assign bus.req_ready = ready;
  assign bus.tx_start = start;
  assign bus.tx_data = data;
  assign bus.grant_valid = gv;
  assign bus.grant_id = gid;
  assign bus.timeout_flag = tflag;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with queue-fed requesters and a 100-cycle busy transmitter model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int BUSY = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(20)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  logic [8:0] src [N][$];
  logic [9:0] sent [$];
  int t_start [$];
  int passed = 0, total = 0, cyc = 0, busy_cnt = 0;
  int unstable = 0, start_busy = 0, ready_bad = 0, r1_ready = 0, tmo = 0;
  int base = 0, r1_before = 0;
  logic [7:0] cur = '0;
  logic [9:0] exp2 [5] = '{{2'd0, 8'h10}, {2'd1, 8'h11}, {2'd2, 8'h12}, {2'd3, 8'h13}, {2'd0, 8'h14}};
  logic [9:0] exp3 [4] = '{{2'd2, 8'h01}, {2'd2, 8'h02}, {2'd2, 8'h03}, {2'd1, 8'h20}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = 1'b0;
      bus.req_last[i] = 1'b0;
      bus.req_data[8*i +: 8] = 8'h00;
      if (src[i].size() != 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_last[i] = src[i][0][8];
        bus.req_data[8*i +: 8] = src[i][0][7:0];
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src[r].push_back({l, d});
    drive();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) src[i].delete();
    drive();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int max_cyc, input string tag);
    int c = 0;
    while (sent.size() < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(sent.size() >= n), 1);
  endtask

  task automatic wait_gv_low(input int max_cyc, input string tag);
    int c = 0;
    while (bus.grant_valid && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(bus.grant_valid), 0);
  endtask

  // requester queues, transmitter busy model and bus monitor, all on the falling edge
  initial begin
    bus.tx_busy = 1'b0;
    drive();
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.tx_start) begin
        if (busy_cnt != 0) start_busy++;
        sent.push_back({bus.grant_id, bus.tx_data});
        t_start.push_back(cyc);
        cur = bus.tx_data;
        busy_cnt = BUSY;
      end else if (busy_cnt != 0) busy_cnt--;
      bus.tx_busy = busy_cnt != 0;
      if (bus.tx_busy && bus.tx_data != cur) unstable++;
      if (bus.timeout_flag) tmo++;
      if (bus.req_ready != 0 && bus.req_ready != (4'(1) << bus.grant_id)) ready_bad++;
      if (bus.req_ready[1]) r1_ready++;
      for (int i = 0; i < N; i++) if (bus.req_ready[i] && src[i].size() != 0) void'(src[i].pop_front());
      drive();
    end
  end

  initial begin
    tick(2);
    check("rst_grant_valid", 32'(bus.grant_valid), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_timeout", 32'(bus.timeout_flag), 0);
    reset = 1'b0;
    push(0, 8'hA5, 1'b1);
    tick(1);
    check("t1_grant_valid", 32'(bus.grant_valid), 1);
    check("t1_grant_id", 32'(bus.grant_id), 0);
    check("t1_no_early_start", 32'(bus.tx_start), 0);
    tick(1);
    check("t1_tx_start", 32'(bus.tx_start), 1);
    check("t1_tx_data", 32'(bus.tx_data), 32'h A5);
    check("t1_req_ready", 32'(bus.req_ready), 32'b0001);
    tick(1);
    check("t1_start_pulse", 32'(bus.tx_start), 0);
    check("t1_ready_pulse", 32'(bus.req_ready), 0);
    tick(50);
    check("t1_locked_while_busy", 32'(bus.grant_valid), 1);
    wait_gv_low(100, "t1_release");
    check("t1_busy_low_at_release", 32'(bus.tx_busy), 0);
    check("t1_data_held", 32'(bus.tx_data), 32'h A5);
    do_reset();
    base = sent.size();
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    push(0, 8'h14, 1'b1);
    wait_sent(base + 5, 700, "t2_all_sent");
    if (sent.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("t2_byte%0d", k), 32'(sent[base+k]), 32'(exp2[k]));
      check("t2_packet_gap", 32'(t_start[base+1] - t_start[base]), 103);
    end
    wait_gv_low(200, "t2_release");
    base = sent.size();
    r1_before = r1_ready;
    push(2, 8'h01, 1'b0);
    push(2, 8'h02, 1'b0);
    push(2, 8'h03, 1'b1);
    tick(1);
    check("t3_grant_id", 32'(bus.grant_id), 2);
    push(1, 8'h20, 1'b1);
    wait_sent(base + 3, 400, "t3_packet_sent");
    check("t3_no_ready1", 32'(r1_ready - r1_before), 0);
    wait_sent(base + 4, 200, "t3_r1_sent");
    if (sent.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("t3_byte%0d", k), 32'(sent[base+k]), 32'(exp3[k]));
      check("t3_byte_gap", 32'(t_start[base+1] - t_start[base]), 102);
    end
    wait_gv_low(200, "t3_release");
    check("t4_no_start_while_busy", 32'(start_busy), 0);
    check("t4_data_stable", 32'(unstable), 0);
    check("t4_ready_only_owner", 32'(ready_bad), 0);
    base = sent.size();
    push(2, 8'h50, 1'b0);
    push(2, 8'h51, 1'b1);
    push(3, 8'h60, 1'b1);
    wait_sent(base + 1, 20, "t5_first_byte");
    tick(5);
    check("t5_owner", 32'(bus.grant_id), 2);
    push(0, 8'h70, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t5_rst_grant_valid", 32'(bus.grant_valid), 0);
    check("t5_rst_grant_id", 32'(bus.grant_id), 0);
    check("t5_rst_tx_start", 32'(bus.tx_start), 0);
    check("t5_rst_tx_data", 32'(bus.tx_data), 0);
    check("t5_rst_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b0;
    wait_sent(base + 2, 200, "t5_after_reset");
    if (sent.size() >= base + 2) check("t5_r0_first", 32'(sent[base+1]), 32'({2'd0, 8'h70}));
    wait_sent(base + 4, 400, "t5_drain");
    if (sent.size() >= base + 4) begin
      check("t5_then_r2", 32'(sent[base+2]), 32'({2'd2, 8'h51}));
      check("t5_then_r3", 32'(sent[base+3]), 32'({2'd3, 8'h60}));
    end
    check("t5_no_start_while_busy", 32'(start_busy), 0);
    wait_gv_low(200, "t5_release");
    do_reset();
    base = sent.size();
    push(1, 8'h40, 1'b0);
    push(2, 8'h41, 1'b1);
    wait_sent(base + 1, 20, "t6_first_byte");
    tick(140);
`ifdef UART_ARB_TIMEOUT_EN
    check("t6_timeout_pulses", 32'(tmo), 1);
    check("t6_next_granted", 32'(sent.size()), 32'(base + 2));
    if (sent.size() >= base + 2) check("t6_next_byte", 32'(sent[base+1]), 32'({2'd2, 8'h41}));
`else
    check("t6_no_timeout", 32'(tmo), 0);
    check("t6_still_locked", 32'(bus.grant_valid), 1);
    check("t6_owner_kept", 32'(bus.grant_id), 1);
    check("t6_nothing_else_sent", 32'(sent.size()), 32'(base + 1));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (start/data/busy interface) among NUM_REQ byte-stream requesters.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte flagged "last" has fully shifted out.
- Sits between the command/telemetry sources and the single uart_tx instance on the board.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the grant index; NUM_REQ <= 2**ID_W.
- TIMEOUT_CYCLES, 5208, idle cycles tolerated mid-packet before forced release; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_valid.
- req_ready  output  NUM_REQ  one-cycle pulse: byte from requester i accepted.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to the transmitter; held stable from the start pulse until the byte completes.
- tx_busy  input  1  transmitter busy (high while shifting).
- grant_valid  output  1  a requester currently owns the transmitter.
- grant_id  output  ID_W  index of the owning requester.
- timeout_flag  output  1  one-cycle pulse on forced release; tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled on posedge clk.
- Reset values:
  - All outputs are 0; state is IDLE.
  - last_grant resets to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-packet aborts immediately: tx_start drops and no req_ready pulses. The transmitter is allowed to finish any byte in flight; the arbiter ignores it.
- All outputs are registered.
- IDLE state:
  - If any req_valid is high, grant the first set bit searching circularly from last_grant+1.
  - On a grant: grant_id <= winner, grant_valid <= 1, go to SEND.
  - Arbitration takes 1 cycle.
- SEND state:
  - Waits until req_valid[grant_id]=1 and tx_busy=0.
  - Then in one cycle: tx_data <= the granted requester's byte, tx_start <= 1, req_ready[grant_id] <= 1, last_q <= req_last[grant_id]. Go to WAIT_ACK.
  - If req_valid drops mid-packet, the arbiter stays in SEND and does not re-arbitrate. The packet lock is kept.
- WAIT_ACK state:
  - tx_start and req_ready return to 0; each is high for exactly 1 cycle.
  - Wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE state:
  - Wait for tx_busy=0.
  - If last_q=1: last_grant <= grant_id, grant_valid <= 0, go to IDLE.
  - Otherwise go back to SEND.
- Latency: from req_valid asserted in IDLE to tx_start = 2 cycles. Back-to-back bytes of one packet are separated by the transmitter frame time plus 2 cycles.
- Only requester grant_id can ever see req_ready. Inputs from non-granted requesters are ignored.
- Simultaneous requests are resolved strictly by round-robin order. Requests that arrive while a packet is locked wait until IDLE.
- A single-byte packet (req_last=1 on the first byte) releases after one byte.
- tx_data and grant_id hold their last values after release. Only grant_valid clears.
- Round-robin pointer wrap: when the search runs past NUM_REQ-1 it continues at index 0.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter (at least 32 bits) counts cycles spent in SEND with req_valid[grant_id]=0. It clears on each accepted byte and on each entry to SEND.
  - When the count reaches TIMEOUT_CYCLES: timeout_flag pulses 1 cycle, last_grant <= grant_id, grant_valid <= 0, go to IDLE.
- Not defined: no counter; a stalled owner holds the transmitter indefinitely; timeout_flag is constant 0.

Test Plan:
- Reset, then req_valid=4'b0001, req_data0=8'hA5, req_last0=1 -> grant_id=0, tx_start pulse 2 cycles after req_valid, tx_data=8'hA5, req_ready=4'b0001 for 1 cycle; grant_valid clears after tx_busy falls.
- All four requesters valid continuously, each sending single-byte packets 8'h10..8'h13 -> grants in order 0,1,2,3,0; transmitted bytes follow the same order.
- Requester 2 sends a 3-byte packet 8'h01,8'h02,8'h03 (last on the 3rd) while requester 1 is valid throughout -> all three bytes go out before grant_id=1; req_ready[1] never pulses during the packet.
- Model tx_busy as high for 100 cycles after each start -> the next tx_start occurs only after busy falls; tx_data stays stable throughout each busy period.
- Assert reset in WAIT_DONE mid-packet -> all outputs are 0 the next cycle; on release, requester 0 has priority again.
- With UART_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=20, the owner drops req_valid after its first non-last byte -> timeout_flag pulses 20 cycles later and the next valid requester is granted. Without the macro: the arbiter stays in SEND and timeout_flag stays 0.
